// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [WIDTH-1:0] din,
    input  logic             deq,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow,
`endif
    output logic             full,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             write_ok;
    logic             read_ok;

    // Acceptance uses the registered flags, so requests against a full or empty FIFO are dropped.
    always_comb begin
        write_ok   = enq & ~full;
        read_ok    = deq & ~empty;
        count_next = count;
        if (write_ok && !read_ok) begin
            count_next = count + 1'b1;
        end else if (read_ok && !write_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Storage is intentionally left out of reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // A new error event wins over a clear arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (enq && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (deq && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo; expected values are hand-derived.
// Error-flag checks are included when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

    logic       clk;
    logic       reset;
    logic       enq;
    logic [7:0] din;
    logic       deq;
    logic       full;
    logic [7:0] dout;
    logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       err_clr;
    logic       overflow;
    logic       underflow;
`endif

    int n_checks;
    int n_fail;
    logic [7:0] fill_vals [8];

    sync_fifo #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enq       (enq),
        .din       (din),
        .deq       (deq),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .full      (full),
        .dout      (dout),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request cycle between falling edges; outputs are settled 1ns after the rising edge.
    task automatic apply_stimulus(input logic e, input logic [7:0] d, input logic q);
        @(negedge clk);
        enq = e;
        din = d;
        deq = q;
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        enq = 1'b0;
        deq = 1'b0;
        din = 8'h00;
        reset = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_empty", {7'd0, empty}, 8'h01);
        check_output("reset_full",  {7'd0, full},  8'h00);
        check_output("reset_dout",  dout,          8'h00);
`ifdef FIFO_ERR_FLAGS_EN
        check_output("reset_ovf", {7'd0, overflow},  8'h00);
        check_output("reset_udf", {7'd0, underflow}, 8'h00);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Basic ordering
        apply_stimulus(1'b1, 8'h11, 1'b0);
        check_output("s1_empty_after_first", {7'd0, empty}, 8'h00);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0);
        check_output("s1_empty", {7'd0, empty}, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s1_pop0", dout, 8'h11);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s1_pop1", dout, 8'h22);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s1_pop2", dout, 8'h33);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s1_pop3", dout, 8'h44);
        check_output("s1_empty_end", {7'd0, empty}, 8'h01);

        // Fill to full with random bytes, then an overflowing enq
        for (int i = 0; i < 8; i++) begin
            fill_vals[i] = 8'($urandom_range(0, 255));
            if (fill_vals[i] == 8'hA5) fill_vals[i] = 8'h5A;
            apply_stimulus(1'b1, fill_vals[i], 1'b0);
            if (i == 6) check_output("s2_full_at_7", {7'd0, full}, 8'h00);
        end
        check_output("s2_full_at_8", {7'd0, full}, 8'h01);
        apply_stimulus(1'b1, 8'hA5, 1'b0);
        check_output("s2_full_after_extra", {7'd0, full}, 8'h01);
        check_output("s2_dout_unchanged", dout, 8'h44);
`ifdef FIFO_ERR_FLAGS_EN
        check_output("s2_overflow", {7'd0, overflow}, 8'h01);
`endif

        // Drain, then an underflowing deq
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1);
            check_output($sformatf("s3_pop%0d", i), dout, fill_vals[i]);
        end
        check_output("s3_empty", {7'd0, empty}, 8'h01);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s3_dout_hold", dout, fill_vals[7]);
        check_output("s3_empty_hold", {7'd0, empty}, 8'h01);
`ifdef FIFO_ERR_FLAGS_EN
        check_output("s3_underflow", {7'd0, underflow}, 8'h01);
        check_output("s3_overflow_sticky", {7'd0, overflow}, 8'h01);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_output("s3_ovf_cleared", {7'd0, overflow}, 8'h00);
        check_output("s3_udf_cleared", {7'd0, underflow}, 8'h00);
        @(negedge clk);
        err_clr = 1'b1;
        deq = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        deq = 1'b0;
        check_output("s3_udf_set_beats_clr", {7'd0, underflow}, 8'h01);
`endif

        // Pointer wrap
        for (int i = 0; i < 8; i++) begin
            fill_vals[i] = 8'(8'h60 + i);
            apply_stimulus(1'b1, fill_vals[i], 1'b0);
        end
        check_output("s4_full", {7'd0, full}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1);
            check_output($sformatf("s4_pop%0d", i), dout, fill_vals[i]);
        end
        check_output("s4_not_full", {7'd0, full}, 8'h00);
        apply_stimulus(1'b1, 8'hC0, 1'b0);
        apply_stimulus(1'b1, 8'hC1, 1'b0);
        apply_stimulus(1'b1, 8'hC2, 1'b0);
        check_output("s4_full_again", {7'd0, full}, 8'h01);
        for (int i = 3; i < 8; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1);
            check_output($sformatf("s4_drain%0d", i), dout, fill_vals[i]);
        end
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s4_drain_c0", dout, 8'hC0);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s4_drain_c1", dout, 8'hC1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s4_drain_c2", dout, 8'hC2);
        check_output("s4_empty", {7'd0, empty}, 8'h01);

        // Simultaneous enq and deq on a partly filled FIFO
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'(8'h30 + i), 1'b0);
        apply_stimulus(1'b1, 8'hEE, 1'b1);
        check_output("s5_both_dout", dout, 8'h30);
        check_output("s5_both_empty", {7'd0, empty}, 8'h00);
        check_output("s5_both_full", {7'd0, full}, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s5_pop31", dout, 8'h31);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s5_pop32", dout, 8'h32);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s5_pop33", dout, 8'h33);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s5_popEE", dout, 8'hEE);
        check_output("s5_empty", {7'd0, empty}, 8'h01);

        // Asynchronous reset in the middle of traffic
        apply_stimulus(1'b1, 8'h80, 1'b0);
        apply_stimulus(1'b1, 8'h81, 1'b0);
        apply_stimulus(1'b1, 8'h82, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_output("s6_rst_empty", {7'd0, empty}, 8'h01);
        check_output("s6_rst_full",  {7'd0, full},  8'h00);
        check_output("s6_rst_dout",  dout,          8'h00);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(1'b1, 8'h55, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s6_pop55", dout, 8'h55);
        check_output("s6_empty", {7'd0, empty}, 8'h01);

        // Simultaneous enq and deq while empty: only the write lands
        apply_stimulus(1'b1, 8'h66, 1'b1);
        check_output("s7_dout_hold", dout, 8'h55);
        check_output("s7_not_empty", {7'd0, empty}, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("s7_pop66", dout, 8'h66);
        check_output("s7_empty", {7'd0, empty}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, synchronous first-in first-out buffer with a registered read-data output. Upstream logic pushes words with a one-cycle enq pulse and downstream logic pops them with a one-cycle deq pulse. Full and empty flags provide flow control. The FIFO ignores illegal requests (write when full, read when empty) so they cannot corrupt its state.

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 8, number of storage entries; must be a power of two and at least 4.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
enq  input  1  enqueue request, sampled on rising clk.
din  input  WIDTH  write data, captured with an accepted enq.
deq  input  1  dequeue request, sampled on rising clk.
full  output  1  high when occupancy equals DEPTH.
dout  output  WIDTH  registered read data.
empty  output  1  high when occupancy equals 0.

Behaviour:
- Storage: DEPTH x WIDTH array; write pointer and read pointer each log2(DEPTH) bits; occupancy counter log2(DEPTH)+1 bits.
- Reset (async assert, deassert sampled on clk):
  - pointers = 0, count = 0, empty = 1, full = 0, dout = 0.
  - Array contents are not cleared.
  - Reset asserted mid-operation discards all stored data immediately.
- Acceptance rules, evaluated on each rising edge using pre-edge state:
  - write_ok = enq & ~full.
  - read_ok = deq & ~empty.
- write_ok: mem[wr_ptr] <= din; wr_ptr increments, modulo DEPTH (natural wrap).
- read_ok:
  - dout <= mem[rd_ptr]; rd_ptr increments, modulo DEPTH.
  - Latency: deq asserted before edge N puts the data on dout after edge N, stable for sampling at edge N+1.
- dout holds its last value when no read is accepted, including rejected deq.
- Count update:
  - write_ok only: +1.
  - read_ok only: -1.
  - both: unchanged.
  - neither: unchanged.
- Simultaneous enq and deq:
  - Non-empty, non-full: both accepted, count and flags unchanged, read returns the oldest entry.
  - When empty: only the write is accepted; deq is rejected and dout does not change.
  - When full: only the read is accepted; enq is rejected and din is dropped.
- Flags are registered, derived from next-state count (full = count==DEPTH, empty = count==0), and valid one edge after the accepting edge.
- Rejected enq when full: no state change, din is discarded.
- Rejected deq when empty: no state change.
- Ordering is strictly FIFO across any number of pointer wraps.

Optional Feature:
FIFO_ERR_FLAGS_EN:
- When defined, adds the following ports:
  - output overflow (1 bit): sticky; set on any edge with enq & full.
  - output underflow (1 bit): sticky; set on any edge with deq & empty.
  - input err_clr (1 bit): synchronous clear of both flags, lower priority than setting in the same cycle.
- Both flags reset to 0.
- When not defined, these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then enqueue 0x11, 0x22, 0x33, 0x44 with one-cycle pulses -> empty=0. Dequeue four times -> dout = 0x11, 0x22, 0x33, 0x44 in order, each valid one cycle after its deq edge. Afterwards empty=1.
- Fill from empty with random bytes -> full=1 after exactly DEPTH (8) writes. Extra enq of 0xA5 -> ignored, full stays 1, 0xA5 never appears on dout.
- Drain full FIFO -> every deq accepted, data matches the write order, empty=1 after 8 reads. Extra deq -> ignored, dout unchanged. With FIFO_ERR_FLAGS_EN, underflow=1 (overflow=1 from the previous scenario).
- Wrap test: fill to full, pop 3, push 0xC0, 0xC1, 0xC2 (all accepted, full=1 again), drain -> the remaining 5 original values then 0xC0, 0xC1, 0xC2 in order.
- Preload 0x30..0x33, then assert enq=1 (din=0xEE) and deq=1 for one cycle -> dout=0x30, empty=0 and full=0 unchanged. Drain -> 0x31, 0x32, 0x33, 0xEE.
- Preload 0x80..0x82, assert reset mid-stream -> empty=1, full=0, dout=0 immediately. Subsequent enq 0x55 then deq -> 0x55.
